// File: rtl/mining_job_scheduler_pkg.sv
// Shared types and constants for the mining job scheduler: FSM states,
// result status codes and the layout of the packed job word.
package mining_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_RUN    = 2'd2,
        ST_REPORT = 2'd3
    } sched_state_e;

    localparam logic [1:0] STATUS_FOUND   = 2'b00;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
    localparam logic [1:0] STATUS_ABORTED = 2'b10;

    // Job word layout, MSB first: block_number, prev_hash, transactions, difficulty
    localparam int BLOCK_LSB     = 388;
    localparam int BLOCK_W       = 32;
    localparam int PREV_HASH_LSB = 132;
    localparam int PREV_HASH_W   = 256;
    localparam int TXN_LSB       = 4;
    localparam int TXN_W         = 128;
    localparam int DIFF_LSB      = 0;
    localparam int DIFF_W        = 4;

endpackage

// File: rtl/mining_job_scheduler_job_fifo.sv
// Synchronous job queue; DEPTH must be a power of two so the pointers
// wrap naturally. Simultaneous push and pop both take effect.
module job_fifo #(
    parameter int WIDTH = 420,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wptr_r;
    logic [AW-1:0]    rptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign rdata     = mem_r[rptr_r];

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mining_job_scheduler.sv
// Feeds queued mining jobs to a miner core one at a time, enforces an
// optional per-job cycle budget and reports FOUND/TIMEOUT/ABORTED results.
module mining_job_scheduler
    import mining_sched_pkg::*;
#(
    parameter int JOB_W  = 420,
    parameter int QDEPTH = 2,
    parameter int TMR_W  = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [JOB_W-1:0] job_data,
    input  logic [TMR_W-1:0] timeout_cycles,
    input  logic             abort,
    output logic             core_rst,
    output logic [JOB_W-1:0] core_data,
    input  logic [255:0]     core_hash,
    input  logic [31:0]      core_nonce,
    input  logic             core_valid,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [255:0]     res_hash,
    output logic [31:0]      res_nonce,
    output logic [31:0]      res_block,
    output logic [1:0]       res_status,
    output logic             busy
);

    sched_state_e     state_r;
    logic [JOB_W-1:0] core_data_r;
    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] tmo_r;
    logic             core_rst_r;
    logic             res_valid_r;
    logic [255:0]     res_hash_r;
    logic [31:0]      res_nonce_r;
    logic [31:0]      res_block_r;
    logic [1:0]       res_status_r;

    logic             fifo_push_s;
    logic             fifo_pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [JOB_W-1:0] fifo_head_s;
    logic             timeout_hit_s;

    assign fifo_push_s   = job_valid & job_ready;
    assign fifo_pop_s    = (state_r == ST_IDLE) & ~fifo_empty_s;
    assign timeout_hit_s = (tmo_r != '0) && (timer_r == (tmo_r - TMR_W'(1)));

    job_fifo #(
        .WIDTH (JOB_W),
        .DEPTH (QDEPTH)
    ) u_job_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .wdata (job_data),
        .rdata (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Reset is folded in so no job can be accepted while rst is held.
    assign job_ready  = ~fifo_full_s & ~rst;
    assign busy       = (state_r != ST_IDLE) | ~fifo_empty_s;
    assign core_rst   = core_rst_r;
    assign core_data  = core_data_r;
    assign res_valid  = res_valid_r;
    assign res_hash   = res_hash_r;
    assign res_nonce  = res_nonce_r;
    assign res_block  = res_block_r;
    assign res_status = res_status_r;

    // Job lifecycle FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            core_data_r  <= '0;
            timer_r      <= '0;
            tmo_r        <= '0;
            core_rst_r   <= 1'b1;
            res_valid_r  <= 1'b0;
            res_hash_r   <= '0;
            res_nonce_r  <= '0;
            res_block_r  <= '0;
            res_status_r <= STATUS_FOUND;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        core_data_r <= fifo_head_s;
                        state_r     <= ST_START;
                    end
                end
                ST_START: begin
                    timer_r    <= '0;
                    tmo_r      <= timeout_cycles;
                    core_rst_r <= 1'b0;
                    state_r    <= ST_RUN;
                end
                ST_RUN: begin
                    if (timer_r != {TMR_W{1'b1}}) begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
                    // A result found in the same cycle as abort/timeout still wins.
                    if (core_valid) begin
                        res_hash_r   <= core_hash;
                        res_nonce_r  <= core_nonce;
                        res_status_r <= STATUS_FOUND;
                    end else if (abort) begin
                        res_hash_r   <= '0;
                        res_nonce_r  <= '0;
                        res_status_r <= STATUS_ABORTED;
                    end else if (timeout_hit_s) begin
                        res_hash_r   <= '0;
                        res_nonce_r  <= '0;
                        res_status_r <= STATUS_TIMEOUT;
                    end
                    if (core_valid || abort || timeout_hit_s) begin
                        res_block_r <= core_data_r[BLOCK_LSB +: BLOCK_W];
                        res_valid_r <= 1'b1;
                        core_rst_r  <= 1'b1;
                        state_r     <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    core_rst_r  <= 1'b1;
                    res_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mining_job_scheduler.md
MINING_JOB_SCHEDULER -- requirements
Module: mining_job_scheduler

Interface
REQ-001 Parameter: JOB_W, 420, width of one packed job word {block_number[419:388], prev_hash[387:132], transactions[131:4], difficulty[3:0]}.
REQ-002 Parameter: QDEPTH, 2, job queue depth in entries, power of two.
REQ-003 Parameter: TMR_W, 24, width of the timeout timer and of timeout_cycles.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 job_valid / job_ready  in / out  1 / 1  host job handshake; transfer when both are high.
REQ-007 job_data  in  JOB_W  packed job word.
REQ-008 timeout_cycles  in  TMR_W  RUN budget per job; 0 = no timeout; sampled on entry to START.
REQ-009 abort  in  1  one-cycle pulse that cancels the running job.
REQ-010 core_rst  out  1  restart/hold control to the miner core.
REQ-011 core_data  out  JOB_W  job word driven to the miner core; stable whenever core_rst=0.
REQ-012 core_hash / core_nonce / core_valid  in  256 / 32 / 1  miner core result.
REQ-013 res_valid / res_ready  out / in  1 / 1  result handshake to the host.
REQ-014 res_hash / res_nonce / res_block  out  256 / 32 / 32  result payload; res_block = core_data[419:388] of the reported job.
REQ-015 res_status  out  2  00 FOUND, 01 TIMEOUT, 10 ABORTED.
REQ-016 busy  out  1  high when the state is not IDLE or the queue is non-empty.

Function
REQ-017 The job queue SHALL be a synchronous FIFO of QDEPTH entries; job_ready = !full; push on job_valid&&job_ready.
REQ-018 A push and a pop in the same cycle SHALL both take effect; the occupancy is unchanged.
REQ-019 FSM states SHALL be IDLE, START, RUN and REPORT.
REQ-020 IDLE: if the queue is non-empty, pop the head into the core_data register and go to START; otherwise stay in IDLE.
REQ-021 START lasts exactly one cycle: core_rst=1, timer cleared, timeout_cycles latched; the next state is RUN.
REQ-022 RUN: core_rst=0; the timer increments by 1 each cycle and saturates at its maximum.
REQ-023 RUN exit priority within one cycle: core_valid (capture core_hash and core_nonce, FOUND) > abort (ABORTED) > timer == latched timeout-1 with latched timeout != 0 (TIMEOUT); each exit goes to REPORT.
REQ-024 On ABORTED or TIMEOUT, res_hash and res_nonce SHALL be 0.
REQ-025 REPORT: res_valid=1 and the payload SHALL be held stable; core_rst=1; res_valid&&res_ready returns the FSM to IDLE.
REQ-026 core_rst SHALL be 1 in every state except RUN.
REQ-027 core_valid SHALL be ignored outside RUN; abort SHALL be ignored outside RUN.
REQ-028 Latency: a job pushed at cycle T into an empty, idle block gives START at T+2 and the first RUN cycle at T+3.
REQ-029 Only one job is in flight at a time; jobs complete in FIFO order.

Reset
REQ-030 rst SHALL, synchronously and from any state including mid-RUN or mid-REPORT, empty the queue, set the state to IDLE, and clear core_data, the timer and the result registers to 0.
REQ-031 Output values during and after reset: core_rst=1, res_valid=0, res_status=00, busy=0, job_ready=0 while rst is high, job_ready=1 on the first cycle after.

Structure
REQ-032 Package mining_sched_pkg SHALL hold the FSM state enum, the res_status codes, and the job field offsets and widths.
REQ-033 The queue SHALL be a sub-module job_fifo (width JOB_W, depth QDEPTH) with push/pop/full/empty ports.

Verification
REQ-034 Job with block_number=0x00000005, timeout 1000; core_valid pulsed on RUN cycle 10 with nonce 0x0000ABCD -> res_valid with FOUND, res_nonce=0x0000ABCD, res_block=5.
REQ-035 timeout_cycles=8, core_valid never asserted -> exactly 8 RUN cycles, then REPORT with TIMEOUT and res_hash=0.
REQ-036 core_valid and abort in the same RUN cycle -> FOUND; abort alone on RUN cycle 3 -> ABORTED; core_rst=1 from the next cycle.
REQ-037 Push 3 jobs back-to-back with QDEPTH=2 and res_ready tied high -> job_ready drops as required; jobs are reported in order with block_numbers 1, 2, 3.
REQ-038 res_ready held low for 20 cycles in REPORT -> payload stable throughout and no new START; rst asserted mid-RUN -> next cycle IDLE, busy=0, core_rst=1, and the queue is empty.
